bp_fe_ras: RTL and testbench

- Return address stack for the front end. It sits directly downstream of the instruction-scan stage and consumes its scan class (call/ret) and its compressed flag.
- On a call it pushes the fall-through PC. On a return it supplies the predicted target from the top of the stack.
- Provides a checkpoint/restore interface so the BE-redirect path can repair speculative pointer corruption.
- Purely front-end. Feeds the next-PC selection logic.

---
 rtl/bp_fe_pkg.sv | 32 +++
 rtl/bp_fe_ras_mem.sv | 29 ++
 rtl/bp_fe_ras.sv | 130 +++++++++++++
 tb/tb_bp_fe_ras.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// Front-end shared types: instruction-scan classes and return-address-stack
// checkpoint sizing helpers.
`ifndef BP_FE_PKG_MACROS
`define BP_FE_PKG_MACROS
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2((x)))
`define BP_FE_INSTR_SCAN_CLASS_WIDTH 3
`define BP_FE_RAS_CHECKPOINT_WIDTH(entries) (`BSG_SAFE_CLOG2((entries)+1) + `BSG_SAFE_CLOG2((entries)))
`endif

package bp_fe_pkg;

    localparam int bp_fe_instr_scan_class_width = 3;

    typedef enum logic [bp_fe_instr_scan_class_width-1:0] {
        e_rvi_branch = 3'd0,
        e_rvi_jalr   = 3'd1,
        e_rvi_jal    = 3'd2,
        e_rvi_call   = 3'd3,
        e_rvi_ret    = 3'd4,
        e_default    = 3'd5
    } bp_fe_instr_scan_class_e;

    function automatic int bsg_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // A checkpoint is {count, tos}; count needs one more state than tos.
    function automatic int bp_fe_ras_checkpoint_width(input int entries);
        return bsg_safe_clog2(entries + 1) + bsg_safe_clog2(entries);
    endfunction

endpackage

// File: rtl/bp_fe_ras_mem.sv
// Return-address storage: one synchronous write port, one asynchronous read
// port. Contents are intentionally not reset.
module bp_fe_ras_mem
    import bp_fe_pkg::*;
#(
    parameter int  els_p        = 8,
    parameter int  width_p      = 64,
    localparam int addr_width_lp = bsg_safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    // Write port
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_ras.sv
// Front-end return address stack: pushes fall-through PCs on calls, predicts
// return targets from top of stack, and supports pointer checkpoint/restore.
module bp_fe_ras_chk #(
    parameter int ras_entries_p = 8,
    parameter int cnt_width_lp  = 4
) (
    input logic                    clk_i,
    input logic                    reset_i,
    input logic                    flush_i,
    input logic                    restore_v_i,
    input logic [cnt_width_lp-1:0] restore_count_i
);

    // A restored occupancy beyond the stack depth cannot come from a real checkpoint
    always @(posedge clk_i) begin
        if (!reset_i && !flush_i && restore_v_i) begin
            assert (restore_count_i <= cnt_width_lp'(ras_entries_p));
        end
    end

endmodule

module bp_fe_ras
    import bp_fe_pkg::*;
#(
    parameter int  eaddr_width_p = 64,
    parameter int  ras_entries_p = 8,
    localparam int ptr_width_lp  = bsg_safe_clog2(ras_entries_p),
    localparam int cnt_width_lp  = bsg_safe_clog2(ras_entries_p + 1)
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                scan_v_i,
    input  bp_fe_instr_scan_class_e             scan_class_i,
    input  logic                                is_compressed_i,
    input  logic [eaddr_width_p-1:0]            pc_i,
    output logic                                ret_v_o,
    output logic [eaddr_width_p-1:0]            ret_addr_o,
    output logic [cnt_width_lp+ptr_width_lp-1:0] checkpoint_o,
    input  logic                                restore_v_i,
    input  logic [cnt_width_lp+ptr_width_lp-1:0] restore_i,
    input  logic                                flush_i
);

    typedef struct packed {
        logic [cnt_width_lp-1:0] count;
        logic [ptr_width_lp-1:0] tos;
    } bp_fe_ras_checkpoint_s;

    localparam logic [cnt_width_lp-1:0] full_count_lp = cnt_width_lp'(ras_entries_p);

    logic [ptr_width_lp-1:0]  tos_q, tos_d, tos_inc_s, tos_dec_s;
    logic [cnt_width_lp-1:0]  count_q, count_d;
    logic                     non_empty_s, push_s, pop_s, mem_w_v_s;
    logic [eaddr_width_p-1:0] link_s, mem_r_data_s;
    bp_fe_ras_checkpoint_s    restore_s;

    assign restore_s   = bp_fe_ras_checkpoint_s'(restore_i);
    assign non_empty_s = (count_q != {cnt_width_lp{1'b0}});
    assign push_s      = scan_v_i & (scan_class_i == e_rvi_call);
    assign pop_s       = scan_v_i & (scan_class_i == e_rvi_ret) & non_empty_s;
    // Depth is a power of two, so pointer arithmetic wraps for free
    assign tos_inc_s   = tos_q + ptr_width_lp'(1);
    assign tos_dec_s   = tos_q - ptr_width_lp'(1);
    assign link_s      = pc_i + (is_compressed_i ? eaddr_width_p'(64'd2) : eaddr_width_p'(64'd4));

    // Next pointer state: flush beats restore beats the scan operation
    always_comb begin
        tos_d     = tos_q;
        count_d   = count_q;
        mem_w_v_s = 1'b0;
        if (flush_i) begin
            tos_d   = {ptr_width_lp{1'b0}};
            count_d = {cnt_width_lp{1'b0}};
        end else if (restore_v_i) begin
            tos_d   = restore_s.tos;
            count_d = restore_s.count;
        end else if (push_s) begin
            tos_d     = tos_inc_s;
            mem_w_v_s = 1'b1;
            // A full stack keeps its count; the oldest slot is overwritten
            count_d   = (count_q == full_count_lp) ? count_q : count_q + cnt_width_lp'(1);
        end else if (pop_s) begin
            tos_d   = tos_dec_s;
            count_d = count_q - cnt_width_lp'(1);
        end else begin
            tos_d   = tos_q;
            count_d = count_q;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tos_q   <= {ptr_width_lp{1'b0}};
            count_q <= {cnt_width_lp{1'b0}};
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
        end
    end

    bp_fe_ras_mem #(
        .els_p   (ras_entries_p),
        .width_p (eaddr_width_p)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (mem_w_v_s & ~reset_i),
        .w_addr_i (tos_inc_s),
        .w_data_i (link_s),
        .r_addr_i (tos_q),
        .r_data_o (mem_r_data_s)
    );

    bp_fe_ras_chk #(
        .ras_entries_p (ras_entries_p),
        .cnt_width_lp  (cnt_width_lp)
    ) chk (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .flush_i         (flush_i),
        .restore_v_i     (restore_v_i),
        .restore_count_i (restore_s.count)
    );

    assign ret_v_o      = ~reset_i & pop_s;
    assign ret_addr_o   = (~reset_i & non_empty_s) ? mem_r_data_s : {eaddr_width_p{1'b0}};
    assign checkpoint_o = {count_q, tos_q};

endmodule

// File: tb/tb_bp_fe_ras.sv
// Directed self-checking bench for bp_fe_ras (64-bit addresses, 8 entries).
module tb_bp_fe_ras;
    import bp_fe_pkg::*;

    logic                    clk;
    logic                    reset_i;
    logic                    scan_v_i;
    bp_fe_instr_scan_class_e scan_class_i;
    logic                    is_compressed_i;
    logic [63:0]             pc_i;
    logic                    ret_v_o;
    logic [63:0]             ret_addr_o;
    logic [6:0]              checkpoint_o;
    logic                    restore_v_i;
    logic [6:0]              restore_i;
    logic                    flush_i;

    int n_checks = 0;
    int n_errors = 0;

    bp_fe_ras #(.eaddr_width_p(64), .ras_entries_p(8)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .scan_v_i        (scan_v_i),
        .scan_class_i    (scan_class_i),
        .is_compressed_i (is_compressed_i),
        .pc_i            (pc_i),
        .ret_v_o         (ret_v_o),
        .ret_addr_o      (ret_addr_o),
        .checkpoint_o    (checkpoint_o),
        .restore_v_i     (restore_v_i),
        .restore_i       (restore_i),
        .flush_i         (flush_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        scan_v_i        = 1'b0;
        scan_class_i    = e_default;
        is_compressed_i = 1'b0;
        pc_i            = 64'h0;
        restore_v_i     = 1'b0;
        restore_i       = 7'h00;
        flush_i         = 1'b0;
    endtask

    task automatic scan(input bp_fe_instr_scan_class_e cls, input logic comp, input logic [63:0] pc);
        idle();
        scan_v_i        = 1'b1;
        scan_class_i    = cls;
        is_compressed_i = comp;
        pc_i            = pc;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        reset_i = 1'b1;
        idle();
        tick();
        tick();

        // Outputs held low while in reset even with a ret scan presented
        scan(e_rvi_ret, 1'b0, 64'h1000);
        #1;
        check_eq("reset_ret_v", {63'd0, ret_v_o}, 64'd0);
        check_eq("reset_ret_addr", ret_addr_o, 64'h0);
        tick();
        reset_i = 1'b0;

        scan(e_rvi_ret, 1'b0, 64'h1000);
        #1;
        check_eq("empty_ret_v", {63'd0, ret_v_o}, 64'd0);
        check_eq("empty_ret_addr", ret_addr_o, 64'h0);
        check_eq("empty_ckpt", {57'd0, checkpoint_o}, 64'h00);
        tick();

        // Call then immediate ret
        scan(e_rvi_call, 1'b0, 64'h2000);
        tick();
        scan(e_rvi_ret, 1'b0, 64'h2010);
        #1;
        check_eq("callret_v", {63'd0, ret_v_o}, 64'd1);
        check_eq("callret_addr", ret_addr_o, 64'h2004);
        check_eq("callret_ckpt", {57'd0, checkpoint_o}, 64'h09);
        tick();
        #1;
        check_eq("after_pop_ckpt", {57'd0, checkpoint_o}, 64'h00);

        // Compressed call
        scan(e_rvi_call, 1'b1, 64'h3000);
        tick();
        #1;
        check_eq("rvc_addr", ret_addr_o, 64'h3002);
        check_eq("rvc_noscan_v", {63'd0, ret_v_o}, 64'd0);
        flush_i = 1'b1;
        tick();
        #1;
        check_eq("flush_ckpt", {57'd0, checkpoint_o}, 64'h00);
        check_eq("flush_addr", ret_addr_o, 64'h0);

        // Overflow: nine calls into eight entries
        for (int k = 1; k <= 9; k++) begin
            scan(e_rvi_call, 1'b0, 64'h100 * k);
            tick();
        end
        #1;
        check_eq("full_ckpt", {57'd0, checkpoint_o}, 64'h41);
        for (int i = 0; i < 8; i++) begin
            scan(e_rvi_ret, 1'b0, 64'h8000);
            #1;
            check_eq($sformatf("ovf_ret%0d_v", i), {63'd0, ret_v_o}, 64'd1);
            check_eq($sformatf("ovf_ret%0d_addr", i), ret_addr_o, 64'h904 - 64'h100 * i);
            tick();
        end
        scan(e_rvi_ret, 1'b0, 64'h8000);
        #1;
        check_eq("ovf_ret8_v", {63'd0, ret_v_o}, 64'd0);
        check_eq("ovf_ret8_addr", ret_addr_o, 64'h0);
        tick();
        #1;
        check_eq("ovf_empty_ckpt", {57'd0, checkpoint_o}, 64'h01);
        flush_i = 1'b1;
        tick();

        // Checkpoint / restore across speculative push, pop, push
        scan(e_rvi_call, 1'b0, 64'h4000);
        tick();
        #1;
        check_eq("ckpt_capture", {57'd0, checkpoint_o}, 64'h09);
        scan(e_rvi_call, 1'b0, 64'h5000);
        tick();
        scan(e_rvi_ret, 1'b0, 64'h5100);
        #1;
        check_eq("spec_pop_addr", ret_addr_o, 64'h5004);
        tick();
        scan(e_rvi_call, 1'b0, 64'h6000);
        tick();
        #1;
        check_eq("spec_push_ckpt", {57'd0, checkpoint_o}, 64'h12);
        restore_v_i = 1'b1;
        restore_i   = 7'h09;
        tick();
        scan(e_rvi_ret, 1'b0, 64'h6100);
        #1;
        check_eq("restore_ret_v", {63'd0, ret_v_o}, 64'd1);
        check_eq("restore_ret_addr", ret_addr_o, 64'h4004);
        tick();
        #1;
        check_eq("restore_after_ckpt", {57'd0, checkpoint_o}, 64'h00);

        // Restore and call together: only the restore lands, mem untouched
        scan(e_rvi_call, 1'b0, 64'h7000);
        restore_v_i = 1'b1;
        restore_i   = 7'h09;
        tick();
        #1;
        check_eq("rst_call_ckpt", {57'd0, checkpoint_o}, 64'h09);
        check_eq("rst_call_addr", ret_addr_o, 64'h4004);

        // Non-call/ret classes leave state alone
        scan(e_rvi_jal, 1'b0, 64'h7100);
        tick();
        scan(e_rvi_jalr, 1'b1, 64'h7200);
        tick();
        #1;
        check_eq("other_class_ckpt", {57'd0, checkpoint_o}, 64'h09);

        // Flush beats restore
        flush_i     = 1'b1;
        restore_v_i = 1'b1;
        restore_i   = 7'h12;
        tick();
        #1;
        check_eq("flush_restore_ckpt", {57'd0, checkpoint_o}, 64'h00);

        // Link wraps at the top of the address space
        scan(e_rvi_call, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        scan(e_rvi_ret, 1'b0, 64'h10);
        #1;
        check_eq("wrap_ret_v", {63'd0, ret_v_o}, 64'd1);
        check_eq("wrap_ret_addr", ret_addr_o, 64'h0);
        check_eq("wrap_ckpt", {57'd0, checkpoint_o}, 64'h09);
        tick();

        // Reset beats a simultaneous call and forces outputs low
        scan(e_rvi_call, 1'b0, 64'h9000);
        tick();
        reset_i = 1'b1;
        scan(e_rvi_ret, 1'b0, 64'h9100);
        #1;
        check_eq("reset_mid_v", {63'd0, ret_v_o}, 64'd0);
        check_eq("reset_mid_addr", ret_addr_o, 64'h0);
        scan(e_rvi_call, 1'b0, 64'hA000);
        tick();
        reset_i = 1'b0;
        #1;
        check_eq("reset_mid_ckpt", {57'd0, checkpoint_o}, 64'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
